rpn_stack_engine: RTL and testbench
===================================

# rpn_stack_engine

- Parametrised successor of the team's stack calculator.
- Register-file RPN stack with configurable word width, depth and input-digit width.
- Accepts one command per valid/ready handshake and executes arithmetic and stack-manipulation ops.
- Includes an integrated bit-serial signed divider, a one-cycle completion pulse and a multi-bit error code.
- Sits between the button/switch front end and the display driver; the top-of-stack value feeds the display directly.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (≥ 8)
- DEPTH, 8, maximum stack entries (≥ 2)
- IN_BITS, 8, width of the immediate input digit (≤ WIDTH)

Ports (SW = $clog2(DEPTH+1)):
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when the engine can accept a command
- cmd_op  in  4  opcode, sampled on accept
- cmd_imm  in  IN_BITS  immediate digit for push / shift-push, sampled on accept
- done  out  1  one-cycle pulse when a command completes, whether it succeeds or fails
- err  out  3  result code of the last completed command; held until the next completion
- top_out  out  WIDTH  current top of stack; 0 when the stack is empty
- stack_size  out  SW  number of valid entries
- empty, full  out  1  stack_size==0, stack_size==DEPTH

## Operation
- T = entry[size-1]; S = entry[size-2].
- A command is accepted when cmd_valid && cmd_ready. cmd_valid while busy is ignored.

Opcodes:
- 0 add: T+S
- 1 sub: T−S
- 2 mul: low WIDTH bits of T*S
- 3 div: T/S
- 4 mod: T%S
- 0–4 each need 2 entries, pop both and push the result (size−1).
- 5 pop: needs 1 entry; size−1.
- 6 dup: needs 1 entry; pushes T (size+1).
- 7 swap: needs 2 entries; exchanges T and S.
- 8 push: pushes cmd_imm zero-extended (size+1).
- 9 shift-push: needs 1 entry; T ← (T<<IN_BITS)|cmd_imm, truncated to WIDTH.
- 10 neg: needs 1 entry; T ← −T, two's complement wrap.
- 11 clear: size ← 0; never errors.
- 12–15: illegal.

Arithmetic rules:
- Add, sub, mul and neg wrap modulo 2^WIDTH.
- Div/mod are signed, C semantics: quotient truncates toward zero; remainder takes the sign of T.
- MIN_INT / −1 gives quotient MIN_INT and remainder 0.

err codes (priority in listed order):
- 1 illegal op
- 2 underflow (too few entries)
- 3 overflow (push, dup at full)
- 4 divide by zero (S==0 on div/mod)
- 0 success

On any nonzero err, stack contents and size are unchanged.

State machine:
- IDLE: cmd_ready=1. On accept: div/mod with operands present and S≠0 → DIV; otherwise → EXEC.
- EXEC: apply the op or the error, set done and err on exit → IDLE.
- DIV: restoring divide on operand magnitudes, one quotient bit per cycle, WIDTH cycles → FIX.
- FIX: apply signs, write the result, set done and err → IDLE.

## Timing
- Reset values: cmd_ready=1, done=0, err=0, stack_size=0, top_out=0, empty=1, full=0. Register-file contents are don't-care.
- Accept on edge E0:
  - Non-divide ops: state written and done=1 after edge E0+1.
  - Div/mod: done=1 after edge E0+WIDTH+2.
- cmd_ready is low from after E0 until the done cycle. It is high in the done cycle, so a new command can be accepted back-to-back at the edge ending the done cycle.
- Throughput: 1 command per 2 cycles for non-divide ops.
- top_out, stack_size, empty and full update in the same cycle done rises.
- cmd_op and cmd_imm need only be valid in the accept cycle. Changes while busy have no effect.
- reset_n low at any time, including mid-division, aborts immediately to IDLE with the reset values above. No done is issued for the aborted command.

## Test plan
- Reset, push 7, push 3, sub → top_out=0xFFFFFFFC (3−7), stack_size=1, err=0, done pulses each command 1 cycle after accept.
- Push 0x12, shift-push 0x34, shift-push 0x56 → top_out=0x00123456, stack_size=1.
- Push 2, push 0x80 → neg → … build S=−7 (0xFFFFFFF9) under T=20 is not possible via RPN order, so push −7 via neg, then push 20; div → 0xFFFFFFFE (−2), done exactly WIDTH+2 cycles after accept; repeat with mod → 6.
- Push 0 then push 5 (T=5, S=0), div → err=4, stack_size=2, top_out=5 unchanged.
- DEPTH pushes then dup → err=3, full=1; clear → stack_size=0, empty=1; pop on empty → err=2; op 13 → err=1.
- Start div, assert reset_n low at cycle 10 → cmd_ready=1, stack_size=0, no done pulse; next push completes normally.

Source files
------------

// File: rtl/rpn_stack_engine_if.sv
// Command handshake between the front end and the RPN stack engine.
// The master drives a command; the slave accepts it on valid && ready.
interface rpn_stack_engine_if #(
    parameter int unsigned IN_BITS = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [3:0]         cmd_op;
    logic [IN_BITS-1:0] cmd_imm;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/rpn_stack_engine.sv
// Register-file RPN stack calculator with a bit-serial signed divider.
// One command per handshake; done pulses for one cycle with the result code in err.
module rpn_stack_engine #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned IN_BITS = 8,
    localparam int unsigned SW     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rpn_stack_engine_if.slave    cmd,
    output logic                 done,
    output logic [2:0]           err,
    output logic [WIDTH-1:0]     top_out,
    output logic [SW-1:0]        stack_size,
    output logic                 empty,
    output logic                 full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StFix  = 2'd3;

    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpSub   = 4'd1;
    localparam logic [3:0] OpMul   = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpMod   = 4'd4;
    localparam logic [3:0] OpPop   = 4'd5;
    localparam logic [3:0] OpDup   = 4'd6;
    localparam logic [3:0] OpSwap  = 4'd7;
    localparam logic [3:0] OpPush  = 4'd8;
    localparam logic [3:0] OpShl   = 4'd9;
    localparam logic [3:0] OpNeg   = 4'd10;
    localparam logic [3:0] OpClear = 4'd11;

    localparam logic [2:0] ErrNone    = 3'd0;
    localparam logic [2:0] ErrIllegal = 3'd1;
    localparam logic [2:0] ErrUnder   = 3'd2;
    localparam logic [2:0] ErrOver    = 3'd3;
    localparam logic [2:0] ErrDivZero = 3'd4;

    logic [1:0]         state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [IN_BITS-1:0] imm_q, imm_d;
    logic [SW-1:0]      size_q, size_d;
    logic               done_q, done_d;
    logic [2:0]         err_q, err_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;

    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               we0, we1;
    logic [AW-1:0]      wa0, wa1;
    logic [WIDTH-1:0]   wd0, wd1;

    logic [SW-1:0]      size_m1, size_m2;
    logic [AW-1:0]      idx_t, idx_s, idx_n;
    logic [WIDTH-1:0]   t_val, s_val;
    logic               need1, need2;
    logic [2:0]         exec_err;
    logic [WIDTH:0]     rem_sh, diff;

    assign size_m1 = size_q - SW'(1);
    assign size_m2 = size_q - SW'(2);
    assign idx_t   = size_m1[AW-1:0];
    assign idx_s   = size_m2[AW-1:0];
    assign idx_n   = size_q[AW-1:0];
    assign t_val   = mem_q[idx_t];
    assign s_val   = mem_q[idx_s];

    always_comb begin
        need2 = (op_q <= OpMod) || (op_q == OpSwap);
        need1 = (op_q == OpPop) || (op_q == OpDup) || (op_q == OpShl) || (op_q == OpNeg);
        if (op_q > OpClear) begin
            exec_err = ErrIllegal;
        end else if ((need2 && size_q < SW'(2)) || (need1 && size_q == '0)) begin
            exec_err = ErrUnder;
        end else if ((op_q == OpPush || op_q == OpDup) && size_q == SW'(DEPTH)) begin
            exec_err = ErrOver;
        end else if ((op_q == OpDiv || op_q == OpMod) && s_val == '0) begin
            exec_err = ErrDivZero;
        end else begin
            exec_err = ErrNone;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        imm_d   = imm_q;
        size_d  = size_q;
        done_d  = 1'b0;
        err_d   = err_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        we0     = 1'b0;
        wa0     = '0;
        wd0     = '0;
        we1     = 1'b0;
        wa1     = '0;
        wd1     = '0;
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, dvs_q};

        case (state_q)
            StIdle: begin
                if (cmd.cmd_valid) begin
                    op_d  = cmd.cmd_op;
                    imm_d = cmd.cmd_imm;
                    if ((cmd.cmd_op == OpDiv || cmd.cmd_op == OpMod) &&
                        size_q >= SW'(2) && s_val != '0) begin
                        state_d = StDiv;
                        quo_d   = t_val;
                        dvs_d   = s_val;
                        rem_d   = '0;
                        cnt_d   = '0;
                        rneg_d  = t_val[WIDTH-1];
                        qneg_d  = t_val[WIDTH-1] ^ s_val[WIDTH-1];
                    end else begin
                        state_d = StExec;
                    end
                end
            end

            StExec: begin
                state_d = StIdle;
                done_d  = 1'b1;
                err_d   = exec_err;
                if (exec_err == ErrNone) begin
                    case (op_q)
                        OpAdd, OpSub, OpMul: begin
                            we0    = 1'b1;
                            wa0    = idx_s;
                            wd0    = (op_q == OpAdd) ? t_val + s_val :
                                     (op_q == OpSub) ? t_val - s_val : t_val * s_val;
                            size_d = size_m1;
                        end
                        OpPop: size_d = size_m1;
                        OpDup: begin
                            we0    = 1'b1;
                            wa0    = idx_n;
                            wd0    = t_val;
                            size_d = size_q + SW'(1);
                        end
                        OpSwap: begin
                            we0 = 1'b1;
                            wa0 = idx_t;
                            wd0 = s_val;
                            we1 = 1'b1;
                            wa1 = idx_s;
                            wd1 = t_val;
                        end
                        OpPush: begin
                            we0    = 1'b1;
                            wa0    = idx_n;
                            wd0    = WIDTH'(imm_q);
                            size_d = size_q + SW'(1);
                        end
                        OpShl: begin
                            we0 = 1'b1;
                            wa0 = idx_t;
                            wd0 = (t_val << IN_BITS) | WIDTH'(imm_q);
                        end
                        OpNeg: begin
                            we0 = 1'b1;
                            wa0 = idx_t;
                            wd0 = -t_val;
                        end
                        OpClear: size_d = '0;
                        default: ;
                    endcase
                end
            end

            StDiv: begin
                cnt_d = cnt_q + CW'(1);
                // First cycle converts the latched operands to magnitudes.
                if (cnt_q == '0) begin
                    quo_d = rneg_q ? -quo_q : quo_q;
                    dvs_d = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
                end else begin
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == CW'(WIDTH)) begin
                        state_d = StFix;
                    end
                end
            end

            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                err_d   = ErrNone;
                we0     = 1'b1;
                wa0     = idx_s;
                wd0     = (op_q == OpDiv) ? (qneg_q ? -quo_q : quo_q) :
                                            (rneg_q ? -rem_q : rem_q);
                size_d  = size_m1;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            imm_q   <= '0;
            size_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= ErrNone;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            size_q  <= size_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    // Register file is not reset; the size counter alone defines validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (we0 && wa0 == AW'(i)) begin
                mem_q[i] <= wd0;
            end else if (we1 && wa1 == AW'(i)) begin
                mem_q[i] <= wd1;
            end
        end
    end

    assign cmd.cmd_ready = (state_q == StIdle);
    assign done          = done_q;
    assign err           = err_q;
    assign stack_size    = size_q;
    assign empty         = (size_q == '0);
    assign full          = (size_q == SW'(DEPTH));
    assign top_out       = empty ? '0 : t_val;

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Directed self-checking bench for rpn_stack_engine (WIDTH=32, DEPTH=8, IN_BITS=8).
module tb_rpn_stack_engine;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 8;
    localparam int LAT_EXEC = 2;          // negedges from accept until done is seen
    localparam int LAT_DIV  = WIDTH + 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        done;
    logic [2:0]  err;
    logic [31:0] top_out;
    logic [3:0]  stack_size;
    logic        empty;
    logic        full;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    rpn_stack_engine_if #(.IN_BITS(8)) cmd_if ();

    rpn_stack_engine #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .IN_BITS (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd        (cmd_if),
        .done       (done),
        .err        (err),
        .top_out    (top_out),
        .stack_size (stack_size),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one command at a negedge; returns at the negedge where done is seen.
    task automatic do_cmd(input logic [3:0] op, input logic [7:0] imm, output int l);
        int n = 0;
        while (!cmd_if.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_imm   = imm;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 4'hF;
        cmd_if.cmd_imm   = 8'hA5;
        l = 1;
        while (!done && l < 200) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic op_only(input logic [3:0] op, input logic [7:0] imm);
        int l;
        do_cmd(op, imm, l);
    endtask

    initial begin
        int seen;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 4'd0;
        cmd_if.cmd_imm   = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_size", 32'(stack_size), 32'd0);
        check("rst_top", top_out, 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 3 - 7 with T=3, S=7
        do_cmd(4'd8, 8'd7, lat);
        check("push_lat", 32'(lat), 32'(LAT_EXEC));
        check("push_ready_in_done", 32'(cmd_if.cmd_ready), 32'd1);
        op_only(4'd8, 8'd3);
        do_cmd(4'd1, 8'd0, lat);
        check("sub_lat", 32'(lat), 32'(LAT_EXEC));
        check("sub_top", top_out, 32'hFFFF_FFFC);
        check("sub_size", 32'(stack_size), 32'd1);
        check("sub_err", 32'(err), 32'd0);
        @(negedge clk);
        check("done_pulse_one", 32'(done), 32'd0);

        // Shift-push builds a multi-digit literal
        op_only(4'd11, 8'd0);
        op_only(4'd8, 8'h12);
        op_only(4'd9, 8'h34);
        op_only(4'd9, 8'h56);
        check("shl_top", top_out, 32'h0012_3456);
        check("shl_size", 32'(stack_size), 32'd1);

        // Add, mul, swap
        op_only(4'd8, 8'd10);
        op_only(4'd0, 8'd0);
        check("add_top", top_out, 32'h0012_3460);
        op_only(4'd8, 8'd16);
        op_only(4'd2, 8'd0);
        check("mul_top", top_out, 32'h0123_4600);
        op_only(4'd8, 8'd5);
        op_only(4'd7, 8'd0);
        check("swap_top", top_out, 32'h0123_4600);
        op_only(4'd5, 8'd0);
        check("pop_top", top_out, 32'd5);

        // 20 / -7 = -2, 20 % -7 = 6
        op_only(4'd11, 8'd0);
        op_only(4'd8, 8'd7);
        op_only(4'd10, 8'd0);
        check("neg_top", top_out, 32'hFFFF_FFF9);
        op_only(4'd8, 8'd20);
        do_cmd(4'd3, 8'd0, lat);
        check("div_lat", 32'(lat), 32'(LAT_DIV));
        check("div_top", top_out, 32'hFFFF_FFFE);
        check("div_size", 32'(stack_size), 32'd1);
        check("div_err", 32'(err), 32'd0);
        op_only(4'd11, 8'd0);
        op_only(4'd8, 8'd7);
        op_only(4'd10, 8'd0);
        op_only(4'd8, 8'd20);
        do_cmd(4'd4, 8'd0, lat);
        check("mod_lat", 32'(lat), 32'(LAT_DIV));
        check("mod_top", top_out, 32'd6);

        // -20 % 7 = -6, -20 / 7 = -2
        op_only(4'd11, 8'd0);
        op_only(4'd8, 8'd7);
        op_only(4'd8, 8'd20);
        op_only(4'd10, 8'd0);
        op_only(4'd4, 8'd0);
        check("mod_negT", top_out, 32'hFFFF_FFFA);
        op_only(4'd11, 8'd0);
        op_only(4'd8, 8'd7);
        op_only(4'd8, 8'd20);
        op_only(4'd10, 8'd0);
        op_only(4'd3, 8'd0);
        check("div_negT", top_out, 32'hFFFF_FFFE);

        // MIN_INT / -1 and MIN_INT % -1
        for (int k = 0; k < 2; k++) begin
            op_only(4'd11, 8'd0);
            op_only(4'd8, 8'd1);
            op_only(4'd10, 8'd0);
            op_only(4'd8, 8'h80);
            op_only(4'd9, 8'h00);
            op_only(4'd9, 8'h00);
            op_only(4'd9, 8'h00);
            op_only((k == 0) ? 4'd3 : 4'd4, 8'd0);
            check((k == 0) ? "minint_div" : "minint_mod", top_out,
                  (k == 0) ? 32'h8000_0000 : 32'd0);
        end

        // Divide by zero leaves the stack untouched
        op_only(4'd11, 8'd0);
        op_only(4'd8, 8'd0);
        op_only(4'd8, 8'd5);
        do_cmd(4'd3, 8'd0, lat);
        check("dz_lat", 32'(lat), 32'(LAT_EXEC));
        check("dz_err", 32'(err), 32'd4);
        check("dz_size", 32'(stack_size), 32'd2);
        check("dz_top", top_out, 32'd5);

        // Full, overflow, clear, underflow, illegal
        op_only(4'd11, 8'd0);
        for (int k = 1; k <= DEPTH; k++) op_only(4'd8, 8'(k));
        check("full_flag", 32'(full), 32'd1);
        op_only(4'd6, 8'd0);
        check("dup_ovf_err", 32'(err), 32'd3);
        check("dup_ovf_size", 32'(stack_size), 32'(DEPTH));
        check("dup_ovf_top", top_out, 32'(DEPTH));
        op_only(4'd8, 8'd99);
        check("push_ovf_err", 32'(err), 32'd3);
        op_only(4'd11, 8'd0);
        check("clr_size", 32'(stack_size), 32'd0);
        check("clr_empty", 32'(empty), 32'd1);
        check("clr_err", 32'(err), 32'd0);
        op_only(4'd5, 8'd0);
        check("pop_udf_err", 32'(err), 32'd2);
        op_only(4'd13, 8'd0);
        check("illegal_err", 32'(err), 32'd1);
        op_only(4'd8, 8'd4);
        op_only(4'd0, 8'd0);
        check("add_udf_err", 32'(err), 32'd2);
        check("add_udf_top", top_out, 32'd4);

        // Reset in the middle of a division
        op_only(4'd11, 8'd0);
        op_only(4'd8, 8'd5);
        op_only(4'd8, 8'd3);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 4'd3;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        seen = 0;
        for (int c = 1; c < 10; c++) begin
            if (done) seen = 1;
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("abort_size", 32'(stack_size), 32'd0);
        check("abort_top", top_out, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_cmd(4'd8, 8'd9, lat);
        check("post_abort_lat", 32'(lat), 32'(LAT_EXEC));
        check("post_abort_top", top_out, 32'd9);
        check("post_abort_size", 32'(stack_size), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
